focus_sharp_stat: RTL and testbench
===================================

Name: focus_sharp_stat

Overview:
- Per-frame image-sharpness statistic generator, directly upstream of the VCM step controller in the autofocus path.
- Takes normalised (active-low) sync pulses, the active-window qualifier and RGB pixels on the video clock.
- Computes luma and the absolute horizontal luma gradient, then accumulates above-threshold gradients inside the window.
- At each frame end, presents a latched sharpness value, a one-cycle valid strobe and an improved-versus-previous-frame flag; the VCM controller hill-climbs on these.

Parameters:
- ACC_W, 24, accumulator and SHARP width in bits; saturating.
- FLUSH_CYC, 3, cycles waited after the frame-end edge before latching, to drain the pixel pipeline; minimum 2.

Ports:
- VIDEO_CLK  in  1  pixel clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- VS  in  1  vertical sync, active-low pulse (already normalised).
- HS  in  1  horizontal sync, active-low pulse (already normalised).
- ACTIV_C  in  1  high while the pixel lies inside the statistic window.
- EN  in  1  accumulation enable; frame timing runs regardless.
- THRESH  in  8  gradient threshold; gradients below it are ignored.
- iR  in  8  red pixel.
- iG  in  8  green pixel.
- iB  in  8  blue pixel.
- Y_OUT  out  8  pipelined luma, for display mixing.
- EDGE_OUT  out  8  pipelined absolute gradient, for display mixing.
- SHARP  out  ACC_W  latched sharpness of the last complete frame.
- SHARP_VALID  out  1  one-cycle strobe when SHARP updates.
- SHARP_UP  out  1  high when the latest SHARP is strictly greater than the previous one.
- FRAME_CNT  out  8  count of latched frames; wraps 255 -> 0.

Behaviour:
- Reset values: all outputs 0, accumulator 0, previous-SHARP register 0, state WAIT_VS.
- Stage 1 (registered):
  - Y1 = (iR + 2*iG + iB) >> 2, computed in a 10-bit sum.
  - Also registers V1 = ACTIV_C & HS.
- Stage 2 (registered):
  - D2 = |Y1 - Yprev|.
  - Yprev holds the Y1 of the previous cycle only while V1 was high on that cycle.
  - First valid pixel of each run (previous V1 = 0) gives D2 = 0.
  - Registers V2 = V1.
  - Y_OUT = Y1 delayed to align with D2; EDGE_OUT = D2. Both are 2 cycles after pixel input.
- Stage 3, accumulation in state ACCUM only:
  - If V2 & EN & (D2 >= THRESH) then acc <= min(acc + D2, 2^ACC_W - 1).
  - Saturation is sticky until the next clear.
- Frame-end event: VS registered once; event = registered VS was 1 and VS is now 0.
- State machine:
  - WAIT_VS: discards the partial frame after reset. On event: acc <= 0, go to ACCUM. No SHARP_VALID.
  - ACCUM: accumulates. On event: go to FLUSH, load the flush counter with FLUSH_CYC - 1.
  - FLUSH: accumulation continues so in-flight pixels are counted. Counter decrements each cycle; at 0 go to LATCH.
  - LATCH (exactly 1 cycle), all in the same edge:
    - SHARP <= acc; SHARP_UP <= (acc > prevSHARP); prevSHARP <= acc.
    - SHARP_VALID <= 1 for this cycle only.
    - FRAME_CNT <= FRAME_CNT + 1; acc <= 0.
    - Go to ACCUM.
- Latency: SHARP_VALID rises FLUSH_CYC + 1 cycles after the VS falling edge is sampled.
- VS events arriving in FLUSH or LATCH are ignored; the next frame's event is handled normally.
- Pixels arriving in LATCH are not accumulated into either frame.
- EN low for a whole frame: SHARP_VALID still pulses with SHARP = 0; SHARP_UP = 0.
- First latched frame after reset: compared against prevSHARP = 0, so SHARP_UP = 1 iff SHARP > 0.
- SHARP, SHARP_UP and FRAME_CNT hold their values between strobes.
- Reset asserted mid-frame: everything clears asynchronously. After release the block waits in WAIT_VS; the first frame it reports is the first complete frame after a VS falling edge.
- THRESH = 0: every valid gradient is accumulated, including zeros (no effect on the sum).
- Max frame value: D2 <= 255 per pixel, so ACC_W = 24 covers 65793 edge pixels before saturating.

Test Plan:
- Reset release then two VS pulses; window is 4 pixels per line for 2 lines with Y sequence 10, 50, 20, 20; THRESH = 15; EN = 1 -> no strobe after the first VS. After the second VS: SHARP = 2*(40+30) = 140; SHARP_VALID is a single pulse 4 cycles after the VS fall; SHARP_UP = 1; FRAME_CNT = 1.
- Same stimulus for the next frame but Y sequence 10, 20, 10, 10 -> gradients 10 and 10 are below threshold, so SHARP = 0, SHARP_UP = 0, FRAME_CNT = 2.
- Pixel pairs alternating 0/255 across a window of 70000 pixels, THRESH = 0 -> SHARP = 16777215 (saturated, no wrap).
- EN = 0 for a full frame with strong edges -> SHARP_VALID pulses, SHARP = 0, Y_OUT and EDGE_OUT still track the input with 2-cycle latency.
- Second VS falling edge injected 1 cycle into FLUSH -> exactly one strobe, and the accumulated value is unaffected by the extra edge.
- RESET_N pulsed low mid-window after 100 accumulated pixels -> outputs 0 immediately; no strobe at the next VS; the first strobe comes at the following VS with that full frame's value.

Source files
------------

// File: rtl/focus_sharp_stat.sv
// ---------------------------------------------------------------------------
// focus_sharp_stat
//
// Per-frame image-sharpness statistic for the autofocus loop. Computes luma
// from RGB, the absolute horizontal luma gradient, and sums the gradients
// that reach THRESH inside the active window. At each frame end the sum is
// latched into SHARP together with a one-cycle SHARP_VALID strobe and a
// SHARP_UP flag (strictly greater than the previous frame).
//
// Handshake: SHARP_VALID is a push-only strobe with no ready. SHARP,
// SHARP_UP and FRAME_CNT change only on the edge that raises SHARP_VALID
// and hold their values until the next strobe.
//
// Ports:
//   VIDEO_CLK   pixel clock, all logic on the rising edge
//   RESET_N     asynchronous active-low reset
//   VS, HS      normalised active-low sync pulses
//   ACTIV_C     high while the pixel is inside the statistic window
//   EN          accumulation enable (frame timing always runs)
//   THRESH      gradient threshold; smaller gradients are ignored
//   iR/iG/iB    8-bit pixel components
//   Y_OUT       luma, 2 cycles after the pixel
//   EDGE_OUT    absolute gradient, 2 cycles after the pixel
//   SHARP       latched sharpness of the last complete frame
//   SHARP_VALID one-cycle strobe when SHARP updates
//   SHARP_UP    latest SHARP strictly greater than the previous one
//   FRAME_CNT   number of latched frames, wraps at 255
//   state_dbg   current FSM state (WAIT_VS=0, ACCUM=1, FLUSH=2, LATCH=3)
// ---------------------------------------------------------------------------
module focus_sharp_stat #(
    parameter int ACC_W     = 24,
    parameter int FLUSH_CYC = 3
) (
    input  logic             VIDEO_CLK,
    input  logic             RESET_N,
    input  logic             VS,
    input  logic             HS,
    input  logic             ACTIV_C,
    input  logic             EN,
    input  logic [7:0]       THRESH,
    input  logic [7:0]       iR,
    input  logic [7:0]       iG,
    input  logic [7:0]       iB,
    output logic [7:0]       Y_OUT,
    output logic [7:0]       EDGE_OUT,
    output logic [ACC_W-1:0] SHARP,
    output logic             SHARP_VALID,
    output logic             SHARP_UP,
    output logic [7:0]       FRAME_CNT,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        ACCUM   = 2'd1,
        FLUSH   = 2'd2,
        LATCH   = 2'd3
    } state_t;

    state_t state, state_nxt;

    // ---------------- stage 1: luma and window qualifier ----------------
    logic [9:0] luma_sum;
    logic [7:0] y1;
    logic       v1;

    assign luma_sum = {2'b00, iR} + {1'b0, iG, 1'b0} + {2'b00, iB};

    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            y1 <= '0;
            v1 <= 1'b0;
        end else begin
            y1 <= 8'(luma_sum >> 2);
            v1 <= ACTIV_C & HS;
        end
    end

    // ---------------- stage 2: absolute horizontal gradient ----------------
    // y_prev only follows y1 while the pixel was valid, so a run that starts
    // after a blanking gap compares against nothing: v2 (the previous v1) is
    // low for the first pixel of every run and forces its gradient to 0.
    logic [7:0] y_prev;
    logic [7:0] y2;
    logic [7:0] d2;
    logic       v2;
    logic [7:0] grad;

    assign grad = (y1 >= y_prev) ? (y1 - y_prev) : (y_prev - y1);

    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            y_prev <= '0;
            y2     <= '0;
            d2     <= '0;
            v2     <= 1'b0;
        end else begin
            if (v1) begin
                y_prev <= y1;
            end
            y2 <= y1;
            d2 <= (v1 && v2) ? grad : 8'd0;
            v2 <= v1;
        end
    end

    assign Y_OUT    = y2;
    assign EDGE_OUT = d2;

    // ---------------- frame-end detection ----------------
    logic vs_d;
    logic frame_end;

    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vs_d <= 1'b0;
        end else begin
            vs_d <= VS;
        end
    end

    assign frame_end = vs_d & ~VS;

    // ---------------- stage 3: saturating accumulator ----------------
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_sat;
    logic             acc_hit;
    logic             acc_open;

    assign acc_sum  = {1'b0, acc} + {{(ACC_W + 1 - 8){1'b0}}, d2};
    // Once the carry-out is set the result pins at all-ones; adding further
    // gradients to an all-ones value carries out again, so it stays pinned.
    assign acc_sat  = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    assign acc_hit  = v2 & EN & (d2 >= THRESH);
    // FLUSH keeps accumulating so pixels still in the pipe at frame end count.
    assign acc_open = (state == ACCUM) || (state == FLUSH);

    // ---------------- FSM ----------------
    logic [CNT_W-1:0] flush_cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_VS: if (frame_end) state_nxt = ACCUM;
            ACCUM:   if (frame_end) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt == '0) state_nxt = LATCH;
            LATCH:   state_nxt = ACCUM;
            default: state_nxt = WAIT_VS;
        endcase
    end

    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= WAIT_VS;
        end else begin
            state <= state_nxt;
        end
    end

    assign state_dbg = state;

    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            flush_cnt <= '0;
        end else if ((state == ACCUM) && frame_end) begin
            flush_cnt <= CNT_W'(FLUSH_CYC - 1);
        end else if ((state == FLUSH) && (flush_cnt != '0)) begin
            flush_cnt <= flush_cnt - 1'b1;
        end
    end

    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc <= '0;
        end else if ((state == WAIT_VS) && frame_end) begin
            acc <= '0;
        end else if (state == LATCH) begin
            // Pixels landing in this cycle belong to neither frame.
            acc <= '0;
        end else if (acc_open && acc_hit) begin
            acc <= acc_sat;
        end
    end

    // ---------------- latched results ----------------
    logic [ACC_W-1:0] prev_sharp;

    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            SHARP       <= '0;
            SHARP_UP    <= 1'b0;
            SHARP_VALID <= 1'b0;
            FRAME_CNT   <= '0;
            prev_sharp  <= '0;
        end else begin
            SHARP_VALID <= (state == LATCH);
            if (state == LATCH) begin
                SHARP      <= acc;
                SHARP_UP   <= (acc > prev_sharp);
                prev_sharp <= acc;
                FRAME_CNT  <= FRAME_CNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_focus_sharp_stat.sv
module tb_focus_sharp_stat;

    localparam int ACC_W     = 24;
    localparam int FLUSH_CYC = 3;
    localparam int STROBE_AT = FLUSH_CYC + 1;

    // ---------------- clock / reset ----------------
    logic             VIDEO_CLK;
    logic             RESET_N;
    logic             VS;
    logic             HS;
    logic             ACTIV_C;
    logic             EN;
    logic [7:0]       THRESH;
    logic [7:0]       iR;
    logic [7:0]       iG;
    logic [7:0]       iB;
    logic [7:0]       Y_OUT;
    logic [7:0]       EDGE_OUT;
    logic [ACC_W-1:0] SHARP;
    logic             SHARP_VALID;
    logic             SHARP_UP;
    logic [7:0]       FRAME_CNT;
    logic [1:0]       state_dbg;

    int total = 0;
    int bad   = 0;

    initial VIDEO_CLK = 1'b0;
    always #5 VIDEO_CLK = ~VIDEO_CLK;

    focus_sharp_stat #(
        .ACC_W    (ACC_W),
        .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .VIDEO_CLK  (VIDEO_CLK),
        .RESET_N    (RESET_N),
        .VS         (VS),
        .HS         (HS),
        .ACTIV_C    (ACTIV_C),
        .EN         (EN),
        .THRESH     (THRESH),
        .iR         (iR),
        .iG         (iG),
        .iB         (iB),
        .Y_OUT      (Y_OUT),
        .EDGE_OUT   (EDGE_OUT),
        .SHARP      (SHARP),
        .SHARP_VALID(SHARP_VALID),
        .SHARP_UP   (SHARP_UP),
        .FRAME_CNT  (FRAME_CNT),
        .state_dbg  (state_dbg)
    );

    // ---------------- driver tasks ----------------
    // Inputs change 1 ns after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge VIDEO_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic pix(input logic [7:0] y, input logic act);
        iR      = y;
        iG      = y;
        iB      = y;
        ACTIV_C = act;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(8'd0, 1'b0);
    endtask

    // One line: HS pulse, short porch, four active pixels, blanking.
    task automatic send_line(input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3);
        HS = 1'b0;
        idle(2);
        HS = 1'b1;
        idle(2);
        pix(p0, 1'b1);
        pix(p1, 1'b1);
        pix(p2, 1'b1);
        pix(p3, 1'b1);
        idle(2);
    endtask

    task automatic send_frame(input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] p3);
        idle(2);
        send_line(p0, p1, p2, p3);
        send_line(p0, p1, p2, p3);
        idle(4);
    endtask

    // Drops VS for one cycle and watches the strobe for a fixed window.
    // second_at > 0 drops VS again on that cycle of the window.
    task automatic vs_check(input string tag, input logic expect_strobe,
                            input logic [ACC_W-1:0] exp_sharp, input logic exp_up,
                            input logic [7:0] exp_cnt, input int second_at);
        int               n_pulse;
        int               first;
        logic [ACC_W-1:0] cap_sharp;
        logic             cap_up;
        logic [7:0]       cap_cnt;
        n_pulse   = 0;
        first     = -1;
        cap_sharp = '0;
        cap_up    = 1'b0;
        cap_cnt   = '0;
        VS = 1'b0;
        tick();
        for (int i = 1; i <= 12; i++) begin
            VS = (i == second_at) ? 1'b0 : 1'b1;
            tick();
            if (SHARP_VALID === 1'b1) begin
                n_pulse++;
                if (first < 0) begin
                    first     = i;
                    cap_sharp = SHARP;
                    cap_up    = SHARP_UP;
                    cap_cnt   = FRAME_CNT;
                end
            end
        end
        VS = 1'b1;
        if (expect_strobe) begin
            chk({tag, "_pulses"}, n_pulse, 1);
            chk({tag, "_latency"}, first, STROBE_AT);
            chk({tag, "_sharp"}, cap_sharp, exp_sharp);
            chk({tag, "_up"}, {31'd0, cap_up}, {31'd0, exp_up});
            chk({tag, "_cnt"}, cap_cnt, exp_cnt);
            chk({tag, "_hold"}, SHARP, exp_sharp);
        end else begin
            chk({tag, "_nostrobe"}, n_pulse, 0);
        end
    endtask

    logic [7:0] t4_y[4];
    logic [7:0] t4_e[4];

    // ---------------- directed sequence ----------------
    initial begin
        RESET_N = 1'b0;
        VS      = 1'b1;
        HS      = 1'b1;
        ACTIV_C = 1'b0;
        EN      = 1'b1;
        THRESH  = 8'd15;
        iR      = '0;
        iG      = '0;
        iB      = '0;
        t4_y    = '{8'd0, 8'd200, 8'd50, 8'd50};
        t4_e    = '{8'd0, 8'd200, 8'd150, 8'd0};

        repeat (3) tick();
        chk("rst_sharp", SHARP, 0);
        chk("rst_valid", {31'd0, SHARP_VALID}, 0);
        chk("rst_up", {31'd0, SHARP_UP}, 0);
        chk("rst_cnt", FRAME_CNT, 0);
        chk("rst_state", state_dbg, 0);
        RESET_N = 1'b1;
        idle(3);

        // Partial frame after reset is discarded.
        vs_check("t1_first_vs", 1'b0, '0, 1'b0, 8'd0, 0);
        // Gradients 0,40,30,0 per line, both >= 15 counted: 2*70.
        send_frame(8'd10, 8'd50, 8'd20, 8'd20);
        vs_check("t1", 1'b1, 24'd140, 1'b1, 8'd1, 0);

        // Gradients 10 and 10 are below threshold.
        send_frame(8'd10, 8'd20, 8'd10, 8'd10);
        vs_check("t2", 1'b1, 24'd0, 1'b0, 8'd2, 0);

        // Saturation: 70000 alternating 0/255 pixels, every gradient counted.
        THRESH = 8'd0;
        idle(2);
        for (int i = 0; i < 70000; i++) pix((i % 2 == 1) ? 8'd255 : 8'd0, 1'b1);
        idle(4);
        vs_check("t3", 1'b1, 24'hFFFFFF, 1'b1, 8'd3, 0);

        // EN low: pipeline outputs still track the pixels, nothing summed.
        EN     = 1'b0;
        THRESH = 8'd15;
        idle(3);
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) pix(t4_y[i], 1'b1);
            else pix(8'd0, 1'b0);
            if (i >= 1) begin
                chk($sformatf("t4_y_out%0d", i - 1), Y_OUT, t4_y[i - 1]);
                chk($sformatf("t4_edge_out%0d", i - 1), EDGE_OUT, t4_e[i - 1]);
            end
        end
        send_frame(8'd0, 8'd200, 8'd50, 8'd50);
        vs_check("t4", 1'b1, 24'd0, 1'b0, 8'd4, 0);

        // Extra VS falling edge one cycle into FLUSH is ignored.
        EN = 1'b1;
        send_frame(8'd10, 8'd50, 8'd20, 8'd20);
        vs_check("t5", 1'b1, 24'd140, 1'b1, 8'd5, 2);
        send_frame(8'd10, 8'd20, 8'd10, 8'd10);
        vs_check("t5_next", 1'b1, 24'd0, 1'b0, 8'd6, 0);

        // Reset in the middle of the window.
        idle(2);
        for (int i = 0; i < 100; i++) pix((i % 2 == 1) ? 8'd100 : 8'd0, 1'b1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("t6_rst_sharp", SHARP, 0);
        chk("t6_rst_cnt", FRAME_CNT, 0);
        chk("t6_rst_up", {31'd0, SHARP_UP}, 0);
        chk("t6_rst_y", Y_OUT, 0);
        chk("t6_rst_edge", EDGE_OUT, 0);
        chk("t6_rst_state", state_dbg, 0);
        tick();
        RESET_N = 1'b1;
        for (int i = 0; i < 20; i++) pix((i % 2 == 1) ? 8'd100 : 8'd0, 1'b1);
        idle(4);
        vs_check("t6_first_vs", 1'b0, '0, 1'b0, 8'd0, 0);
        send_frame(8'd10, 8'd50, 8'd20, 8'd20);
        vs_check("t6", 1'b1, 24'd140, 1'b1, 8'd1, 0);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
